// File: rtl/ram_arbiter.sv
// Shares the single-port system RAM between the CPU bus and the DMA/video fetcher.
// CPU has fixed priority, and a starvation counter forces a DMA slot after DMA_MAX_WAIT losses.
// Grants are registered one cycle after the request is sampled; read data returns one cycle later.
module ram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DMA_MAX_WAIT = 4
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_rd_data
);

  // Issue and return stages share one encoding so a read's owner moves straight from iss to ret.
  localparam logic [1:0] ISS_IDLE = 2'd0;
  localparam logic [1:0] ISS_CPU  = 2'd1;
  localparam logic [1:0] ISS_DMA  = 2'd2;
  localparam logic [1:0] RET_NONE = 2'd0;
  localparam logic [1:0] RET_CPU  = 2'd1;
  localparam logic [1:0] RET_DMA  = 2'd2;

  localparam logic [7:0] MAX_WAIT = DMA_MAX_WAIT[7:0];

  logic [1:0] iss;
  logic [1:0] ret;
  logic [7:0] wait_cnt;
  logic       cpu_wins;
  logic       dma_wins;

  // Pick this edge's winner: DMA takes the slot if alone or once it has lost MAX_WAIT times in a row.
  always_comb begin
    dma_wins = dma_req & (~cpu_req | (wait_cnt >= MAX_WAIT));
    cpu_wins = cpu_req & ~dma_wins;
  end

  // Issue stage: register the winner and its payload onto the RAM port; address/data hold when idle.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      iss         <= ISS_IDLE;
      ram_wren    <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
    end else if (cpu_wins) begin
      iss         <= ISS_CPU;
      ram_wren    <= cpu_we;
      ram_addr    <= cpu_addr;
      ram_wr_data <= cpu_wdata;
    end else if (dma_wins) begin
      iss         <= ISS_DMA;
      ram_wren    <= dma_we;
      ram_addr    <= dma_addr;
      ram_wr_data <= dma_wdata;
    end else begin
      iss      <= ISS_IDLE;
      ram_wren <= 1'b0;
    end
  end

  // Return stage: remember who owns the read the RAM is sampling now, so its data goes back to them.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      ret <= RET_NONE;
    end else if (iss == ISS_CPU && !ram_wren) begin
      ret <= RET_CPU;
    end else if (iss == ISS_DMA && !ram_wren) begin
      ret <= RET_DMA;
    end else begin
      ret <= RET_NONE;
    end
  end

  // Starvation counter: count DMA losses to the CPU, clear on any DMA grant, hold otherwise.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      wait_cnt <= 8'd0;
    end else if (dma_wins) begin
      wait_cnt <= 8'd0;
    end else if (cpu_wins && dma_req && wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign cpu_gnt    = (iss == ISS_CPU);
  assign dma_gnt    = (iss == ISS_DMA);
  assign cpu_rvalid = (ret == RET_CPU);
  assign dma_rvalid = (ret == RET_DMA);
  assign cpu_rdata  = ram_rd_data;
  assign dma_rdata  = ram_rd_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: drives both requesters against a behavioural 1-cycle RAM.
// Read data is checked through per-port expected-data queues popped on rvalid.
// Grant ordering, latency and reset behaviour are checked inline in each scenario task.
module tb_ram_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              sys_clk = 1'b0;
  logic              reset_n;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_wdata, dma_wdata;
  logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [DATA_W-1:0] cpu_rdata, dma_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_rd_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] cpu_q[$];
  logic [7:0] dma_q[$];
  logic [7:0] mon_exp;

  always #5 sys_clk = ~sys_clk;

  ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DMA_MAX_WAIT(4)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wren(ram_wren),
    .ram_rd_data(ram_rd_data)
  );

  // Background contents of locations never written.
  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Behavioural synchronous RAM with 1-cycle read latency.
  logic [7:0] mem [0:65535];
  bit         written [0:65535];
  always @(posedge sys_clk) begin
    if (ram_wren) begin
      mem[ram_addr]     <= ram_wr_data;
      written[ram_addr] <= 1'b1;
    end
    ram_rd_data <= written[ram_addr] ? mem[ram_addr] : pattern(ram_addr);
  end

  // Scoreboard: every rvalid must match the oldest expected item for that port.
  always @(negedge sys_clk) begin
    if (cpu_rvalid) begin
      n_cmp++;
      if (cpu_q.size() == 0) begin
        n_err++;
        $display("FAIL cpu_rdata_unexpected: rvalid with data %h, required no rvalid", cpu_rdata);
      end else begin
        mon_exp = cpu_q.pop_front();
        if (cpu_rdata !== mon_exp) begin
          n_err++;
          $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, mon_exp);
        end
      end
    end
    if (dma_rvalid) begin
      n_cmp++;
      if (dma_q.size() == 0) begin
        n_err++;
        $display("FAIL dma_rdata_unexpected: rvalid with data %h, required no rvalid", dma_rdata);
      end else begin
        mon_exp = dma_q.pop_front();
        if (dma_rdata !== mon_exp) begin
          n_err++;
          $display("FAIL dma_rdata: got %h, required %h", dma_rdata, mon_exp);
        end
      end
    end
  end

  // Single access on one port; for reads, d is the expected read data.
  task automatic access(input bit is_dma, input bit we, input logic [15:0] a, input logic [7:0] d);
    int waited;
    @(negedge sys_clk);
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
      if (!we) dma_q.push_back(d);
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      if (!we) cpu_q.push_back(d);
    end
    waited = 0;
    @(negedge sys_clk);
    while (!(is_dma ? dma_gnt : cpu_gnt) && waited < 20) begin
      @(negedge sys_clk);
      waited++;
    end
    n_cmp++;
    if (waited != 0) begin
      n_err++;
      $display("FAIL %s_gnt_latency: %0d extra cycles, required 0", is_dma ? "dma" : "cpu", waited);
    end
    n_cmp++;
    if (ram_addr !== a || ram_wren !== we || (we && ram_wr_data !== d)) begin
      n_err++;
      $display("FAIL %s_ram_port: addr %h wren %b wdata %h, required addr %h wren %b wdata %h",
               is_dma ? "dma" : "cpu", ram_addr, ram_wren, ram_wr_data, a, we, d);
    end
    if (is_dma) dma_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_wdata = 8'h00;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0050; dma_wdata = 8'h00;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_cmp++;
    if ({cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wren} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: gnt/rvalid/wren %b, required 00000",
               {cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, ram_wren});
    end
    n_cmp++;
    if (ram_addr !== 16'h0000 || ram_wr_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_ram: addr %h wdata %h, required 0000 00", ram_addr, ram_wr_data);
    end
    reset_n = 1'b1;
    cpu_q.push_back(pattern(16'h0040));
    @(negedge sys_clk);
    n_cmp++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_gnt: cpu %b dma %b, required cpu 1 dma 0", cpu_gnt, dma_gnt);
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_cpu_write_read();
    access(1'b0, 1'b1, 16'h8123, 8'hA5);
    @(negedge sys_clk);
    n_cmp++;
    if (ram_wren !== 1'b0) begin
      n_err++;
      $display("FAIL write_wren_width: wren %b one cycle after grant, required 0", ram_wren);
    end
    access(1'b0, 1'b0, 16'h8123, 8'hA5);
    n_cmp++;
    if (cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL read_rvalid_early: rvalid %b in grant cycle, required 0", cpu_rvalid);
    end
    @(negedge sys_clk);
    n_cmp++;
    if (cpu_rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL read_rvalid_latency: rvalid %b two cycles after request, required 1", cpu_rvalid);
    end
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0310;
    @(negedge sys_clk);
    n_cmp++;
    if (cpu_gnt !== 1'b1 || dut.wait_cnt !== 8'd2) begin
      n_err++;
      $display("FAIL midread_pre: cpu_gnt %b wait_cnt %0d, required 1 and 2", cpu_gnt, dut.wait_cnt);
    end
    reset_n = 1'b0;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge sys_clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge sys_clk);
      if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL midread_rvalid: rvalid seen %b after reset, required 0", seen);
    end
    n_cmp++;
    if (dut.wait_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL midread_wait_cnt: %0d, required 0", dut.wait_cnt);
    end
  endtask

  task automatic test_starvation();
    bit         exp_dma;
    logic [7:0] exp_w;
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      exp_dma = (k % 5 == 4);
      exp_w   = exp_dma ? 8'd0 : 8'((k % 5) + 1);
      n_cmp++;
      if (cpu_gnt !== !exp_dma || dma_gnt !== exp_dma) begin
        n_err++;
        $display("FAIL starve_gnt[%0d]: cpu %b dma %b, required cpu %b dma %b",
                 k, cpu_gnt, dma_gnt, !exp_dma, exp_dma);
      end
      n_cmp++;
      if (dut.wait_cnt !== exp_w) begin
        n_err++;
        $display("FAIL starve_wait_cnt[%0d]: %0d, required %0d", k, dut.wait_cnt, exp_w);
      end
      if (exp_dma) dma_q.push_back(pattern(16'h0200));
      else         cpu_q.push_back(pattern(16'h0100));
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_dma_alone();
    @(negedge sys_clk);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0000;
    dma_q.push_back(pattern(16'h0000));
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      n_cmp++;
      if (dma_gnt !== (i < 8) || cpu_gnt !== 1'b0) begin
        n_err++;
        $display("FAIL dma_alone_gnt[%0d]: dma %b cpu %b, required dma %b cpu 0", i, dma_gnt, cpu_gnt, (i < 8));
      end
      n_cmp++;
      if (dma_rvalid !== (i >= 1 && i <= 8)) begin
        n_err++;
        $display("FAIL dma_alone_rvalid[%0d]: %b, required %b", i, dma_rvalid, (i >= 1 && i <= 8));
      end
      if (i < 7) begin
        dma_addr = 16'(i + 1);
        dma_q.push_back(pattern(16'(i + 1)));
      end else begin
        dma_req = 1'b0;
      end
    end
  endtask

  task automatic test_interleave();
    access(1'b0, 1'b1, 16'h0010, 8'h11);
    access(1'b1, 1'b1, 16'h0020, 8'h22);
    @(negedge sys_clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0020;
    cpu_q.push_back(8'h11);
    dma_q.push_back(8'h22);
    @(negedge sys_clk);
    n_cmp++;
    if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin
      n_err++;
      $display("FAIL ilv_slot0: cpu %b dma %b, required cpu 1 dma 0", cpu_gnt, dma_gnt);
    end
    cpu_req = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (dma_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || dma_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ilv_slot1: dma_gnt %b cpu_rvalid %b dma_rvalid %b, required 1 1 0",
               dma_gnt, cpu_rvalid, dma_rvalid);
    end
    dma_req = 1'b0;
    @(negedge sys_clk);
    n_cmp++;
    if (dma_rvalid !== 1'b1 || cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL ilv_slot2: dma_rvalid %b cpu_rvalid %b, required 1 0", dma_rvalid, cpu_rvalid);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_reset_mid_read();
    test_starvation();
    test_dma_alone();
    test_interleave();
    repeat (4) @(negedge sys_clk);
    n_cmp++;
    if (cpu_q.size() != 0 || dma_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: cpu_q %0d dma_q %0d pending, required 0 0", cpu_q.size(), dma_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port system RAM (synchronous block RAM, 1-cycle read latency) between the 6502 CPU bus and a DMA/video-fetch requester. Sits between the CPU bus decode (`ram_s` path) and the `spram` instance, and is clocked by `sys_clk`. CPU has fixed priority. A starvation counter guarantees the DMA port a slot after a bounded number of lost arbitrations. One access is issued per cycle, and reads and writes may be pipelined back-to-back.

## Interface
Parameters:
- ADDR_W, 16, RAM address width
- DATA_W, 8, data width
- DMA_MAX_WAIT, 4, consecutive lost arbitrations after which DMA wins; legal range 1..255

Ports:
- sys_clk  in  1  system clock (100 MHz)
- reset_n  in  1  reset; synchronous, active-low
- cpu_req  in  1  CPU access request; held with addr/we/wdata until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  1-cycle pulse: CPU access is on the RAM port this cycle
- cpu_rvalid  out  1  1-cycle pulse: cpu_rdata valid (reads only)
- cpu_rdata  out  DATA_W  read data, equal to ram_rd_data
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* ports, for the DMA port
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_wr_data  out  DATA_W  RAM write data (registered)
- ram_wren  out  1  RAM write enable (registered)
- ram_rd_data  in  DATA_W  RAM q; valid one cycle after the address is presented

## Operation
- Arbitration runs on every edge and samples cpu_req and dma_req.
  - Only one port requesting: that port wins.
  - Both requesting: CPU wins, unless wait_cnt >= DMA_MAX_WAIT; then DMA wins.
- wait_cnt (8 bits) tracks DMA losses.
  - Increments, saturating at 255, when both ports request and CPU wins.
  - Clears to 0 on any DMA grant.
  - Holds otherwise, including when DMA is not requesting.
- Issue state `iss` holds one of IDLE, CPU, DMA. It is updated every edge to the winner, or IDLE if there is no request.
- Outputs while `iss`=CPU or DMA:
  - ram_addr and ram_wr_data are the winner's addr and wdata.
  - ram_wren equals the winner's we.
  - The winner's gnt is 1.
- While `iss`=IDLE: ram_wren=0, both gnt=0, and ram_addr/ram_wr_data hold their last values.
- Read return stage `ret` holds one of NONE, CPU, DMA. It is loaded from `iss` on every edge, but only when that access was a read (we=0); otherwise it loads NONE.
  - `ret`=CPU gives cpu_rvalid=1; `ret`=DMA gives dma_rvalid=1.
- cpu_rdata and dma_rdata are both driven by ram_rd_data at all times. They are only meaningful with their rvalid.
- Requester protocol:
  - A requester keeps req and its payload stable until it sees gnt.
  - If req is still high at the edge that ends the gnt cycle, that is a new request, and it may carry a new payload.
  - Requesters must not change we, addr or wdata while req=1 and gnt=0.
- Reset (reset_n=0 at an edge) sets the following regardless of in-flight accesses:
  - iss=IDLE, ret=NONE, wait_cnt=0, ram_wren=0, ram_addr=0, ram_wr_data=0.
  - Every gnt and rvalid is 0.
- A read in flight when reset is applied never produces rvalid.
- A write whose gnt cycle coincides with a reset edge has already been presented to the RAM at that edge and completes.

## Timing
- Request sampled high at edge E0 → ram_* and gnt valid in the cycle after E0 (C1) → the RAM samples at E1 → rvalid and rdata valid in C2.
- Read latency: 2 cycles from the first sampled req to rvalid. Write commits at E1.
- Throughput: one access per cycle. Back-to-back reads from one port give consecutive gnt pulses and consecutive rvalid pulses.
- Port switches add no bubble.
- Worst-case DMA wait under continuous CPU traffic: DMA_MAX_WAIT lost cycles, then a grant. The grant pattern is DMA_MAX_WAIT CPU grants, then 1 DMA grant.
- No combinational path from any req to any output; all outputs come from registers, except rdata, which is a pass-through of ram_rd_data.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with both reqs high → all gnt, rvalid and ram_wren are 0, ram_addr=0. One cycle after release, cpu_gnt=1.
- CPU write then read: write 0xA5 to 0x8123, then read 0x8123 → ram_wren=1 for exactly 1 cycle. cpu_rvalid arrives 2 cycles after the read is sampled, with cpu_rdata=0xA5.
- Starvation bound: DMA_MAX_WAIT=4, both reqs held high for 20 cycles → grant sequence CPU,CPU,CPU,CPU,DMA repeating. wait_cnt returns to 0 after each DMA grant.
- DMA alone: dma_req high reading 0x0000..0x0007 back-to-back → 8 consecutive dma_gnt pulses and 8 consecutive dma_rvalid pulses with matching data. cpu_gnt stays 0.
- Interleaved read ownership: CPU reads 0x0010 (data 0x11) while DMA reads 0x0020 (data 0x22) in consecutive slots → cpu_rvalid carries 0x11 and the following dma_rvalid carries 0x22. No cross-delivery.
- Reset mid-read: assert reset_n=0 in the cycle cpu_gnt=1 for a read → cpu_rvalid never pulses. wait_cnt=0 after release.
